neuron_seq_ctrl: RTL

Sequencer that time-multiplexes one shared `mnozenje` multiplier and one weight ROM across the 60 features of a sonar sample. It produces the same sign-magnitude weighted sum and `Sigmoid_LUT` probability as the fully parallel neuron, at one product per cycle. It sits between the sample source and the layer output. It accepts one 960-bit sample per valid/ready handshake and returns one 16-bit probability per valid/ready handshake.

---
 rtl/neuron_seq_ctrl_if.sv | 38 +++
 rtl/neuron_seq_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/neuron_seq_ctrl_if.sv
// Bus bundle for the sequenced neuron: sample handshake, weight ROM port,
// shared multiplier port, sigmoid LUT port and result handshake.
interface neuron_seq_ctrl_if #(
    parameter int unsigned BROJ_ZNACAJKI = 60,
    parameter int unsigned SIRINA        = 16,
    parameter int unsigned SIRINA_SUME   = 22
);
    localparam int unsigned AdrW = $clog2(BROJ_ZNACAJKI);

    logic                              uzorak_valid;
    logic                              uzorak_ready;
    logic [BROJ_ZNACAJKI*SIRINA-1:0]   uzorak;
    logic [AdrW-1:0]                   tezina_adr;
    logic [SIRINA-1:0]                 tezina;
    logic [SIRINA-1:0]                 mnoz_tezina;
    logic [SIRINA-1:0]                 mnoz_uzorak;
    logic [SIRINA-1:0]                 mnoz_produkt;
    logic [SIRINA_SUME-1:0]            suma;
    logic                              predznak;
    logic [SIRINA-1:0]                 vjerojatnost;
    logic [SIRINA-1:0]                 izlaz;
    logic                              izlaz_valid;
    logic                              izlaz_ready;

    // Controller side.
    modport master (
        input  uzorak_valid, uzorak, tezina, mnoz_produkt, vjerojatnost, izlaz_ready,
        output uzorak_ready, tezina_adr, mnoz_tezina, mnoz_uzorak, suma, predznak,
        output izlaz, izlaz_valid
    );

    // Environment side: sample source, ROM, multiplier, LUT and consumer.
    modport slave (
        output uzorak_valid, uzorak, tezina, mnoz_produkt, vjerojatnost, izlaz_ready,
        input  uzorak_ready, tezina_adr, mnoz_tezina, mnoz_uzorak, suma, predznak,
        input  izlaz, izlaz_valid
    );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Sequenced sonar neuron: one shared multiplier and weight ROM, one product per
// cycle over all features, sign-magnitude accumulate, compare, then sigmoid LUT.
module neuron_seq_ctrl #(
    parameter int unsigned BROJ_ZNACAJKI = 60,
    parameter int unsigned SIRINA        = 16,
    parameter int unsigned SIRINA_SUME   = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    neuron_seq_ctrl_if.master bus
);
    localparam int unsigned AdrW = $clog2(BROJ_ZNACAJKI);
    localparam logic [AdrW-1:0] ZadnjiK = AdrW'(BROJ_ZNACAJKI - 1);

    typedef enum logic [2:0] {StIdle, StMac, StCmp, StSig, StOut} state_e;

    state_e                          state_q, state_d;
    logic [BROJ_ZNACAJKI*SIRINA-1:0] uzorak_q, uzorak_d;
    logic [AdrW-1:0]                 k_q, k_d;
    logic [SIRINA_SUME-1:0]          p_acc_q, p_acc_d;
    logic [SIRINA_SUME-1:0]          n_acc_q, n_acc_d;
    logic [SIRINA_SUME-1:0]          suma_q, suma_d;
    logic                            predznak_q, predznak_d;
    logic [SIRINA-1:0]               izlaz_q, izlaz_d;
    logic                            izlaz_valid_q, izlaz_valid_d;
    logic [SIRINA_SUME-1:0]          produkt_ext;

    // Worst case 60 x 0xFFFF fits in the accumulator width, so no wrap handling.
    assign produkt_ext = SIRINA_SUME'(bus.mnoz_produkt);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            uzorak_q      <= '0;
            k_q           <= '0;
            p_acc_q       <= '0;
            n_acc_q       <= '0;
            suma_q        <= '0;
            predznak_q    <= 1'b0;
            izlaz_q       <= '0;
            izlaz_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            uzorak_q      <= uzorak_d;
            k_q           <= k_d;
            p_acc_q       <= p_acc_d;
            n_acc_q       <= n_acc_d;
            suma_q        <= suma_d;
            predznak_q    <= predznak_d;
            izlaz_q       <= izlaz_d;
            izlaz_valid_q <= izlaz_valid_d;
        end
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d       = state_q;
        uzorak_d      = uzorak_q;
        k_d           = k_q;
        p_acc_d       = p_acc_q;
        n_acc_d       = n_acc_q;
        suma_d        = suma_q;
        predznak_d    = predznak_q;
        izlaz_d       = izlaz_q;
        izlaz_valid_d = izlaz_valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.uzorak_valid) begin
                    uzorak_d = bus.uzorak;
                    p_acc_d  = '0;
                    n_acc_d  = '0;
                    k_d      = '0;
                    state_d  = StMac;
                end
            end
            StMac: begin
                // Routing depends on the weight sign bit only, even for zero magnitudes.
                if (bus.tezina[SIRINA-1]) begin
                    n_acc_d = n_acc_q + produkt_ext;
                end else begin
                    p_acc_d = p_acc_q + produkt_ext;
                end
                k_d = k_q + 1'b1;
                if (k_q == ZadnjiK) begin
                    k_d     = '0;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                // A tie counts as negative: suma = 0, predznak = 1.
                if (p_acc_q > n_acc_q) begin
                    suma_d     = p_acc_q - n_acc_q;
                    predznak_d = 1'b0;
                end else begin
                    suma_d     = n_acc_q - p_acc_q;
                    predznak_d = 1'b1;
                end
                state_d = StSig;
            end
            StSig: begin
                izlaz_d       = bus.vjerojatnost;
                izlaz_valid_d = 1'b1;
                state_d       = StOut;
            end
            StOut: begin
                if (bus.izlaz_ready) begin
                    izlaz_valid_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Combinational outputs to the sample source, ROM and multiplier.
    always_comb begin
        bus.uzorak_ready = (state_q == StIdle);
        bus.mnoz_tezina  = bus.tezina;
        bus.tezina_adr   = '0;
        bus.mnoz_uzorak  = '0;
        if (state_q == StMac) begin
            bus.tezina_adr  = k_q;
            bus.mnoz_uzorak = uzorak_q[int'(k_q)*SIRINA +: SIRINA];
        end
    end

    assign bus.suma        = suma_q;
    assign bus.predznak    = predznak_q;
    assign bus.izlaz       = izlaz_q;
    assign bus.izlaz_valid = izlaz_valid_q;
endmodule
